// File: rtl/axi_mem_slave.sv
// axi_mem_slave: single-beat AXI-style memory slave, 2^DEPTH_LOG2 x 32-bit words.
// Independent read and write FSMs; every output is driven from a flop.
// Optional build macro AXI_MEM_SLAVE_WAIT_STATE_EN adds one wait cycle to the
// read path (R_WAIT) and one to the write commit (W_COMMIT held two cycles).
module axi_mem_slave #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        reset,
    // read address channel
    input  logic        ARVALID,
    output logic        ARREADY,
    input  logic [31:0] ARADDR,
    // read data channel
    output logic        RVALID,
    input  logic        RREADY,
    output logic [31:0] RDATA,
    // write address channel
    input  logic        AWVALID,
    output logic        AWREADY,
    input  logic [31:0] AWADDR,
    // write data channel
    input  logic        WVALID,
    output logic        WREADY,
    input  logic [31:0] WDATA,
    // write response channel
    output logic        BVALID,
    input  logic        BREADY
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // R_WAIT is only reachable when the wait-state build is enabled
    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_DATA = 2'd2
    } r_state_e;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_COMMIT = 2'd1,
        W_RESP   = 2'd2
    } w_state_e;

    logic [31:0] mem_q [DEPTH];

    // read path state
    r_state_e              r_state_q, r_state_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  ar_hs_s;
    logic [DEPTH_LOG2-1:0] ar_idx_s;

    // write path state
    w_state_e              w_state_q, w_state_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic [DEPTH_LOG2-1:0] aw_idx_q, aw_idx_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  aw_hs_s;
    logic                  w_hs_s;
    logic                  commit_s;
`ifdef AXI_MEM_SLAVE_WAIT_STATE_EN
    logic                  wcnt_q, wcnt_d;
`endif

    // address bits outside the word index are deliberately ignored (aliasing)
    logic unused_addr_s;
    assign unused_addr_s = ^{ARADDR[31:DEPTH_LOG2+2], ARADDR[1:0],
                             AWADDR[31:DEPTH_LOG2+2], AWADDR[1:0]};

    assign ar_idx_s = ARADDR[DEPTH_LOG2+1:2];
    assign ar_hs_s  = ARVALID & arready_q;
    assign aw_hs_s  = AWVALID & awready_q;
    assign w_hs_s   = WVALID & wready_q;

    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RDATA   = rdata_q;
    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;

    // Read FSM next state: latch data on AR handshake, hold it until R handshake
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs_s) begin
                    // sampled before any same-edge commit, so a colliding
                    // write is not visible to this read
                    rdata_d   = mem_q[ar_idx_s];
                    arready_d = 1'b0;
`ifdef AXI_MEM_SLAVE_WAIT_STATE_EN
                    r_state_d = R_WAIT;
`else
                    r_state_d = R_DATA;
                    rvalid_d  = 1'b1;
`endif
                end else begin
                    r_state_d = R_IDLE;
                end
            end
`ifdef AXI_MEM_SLAVE_WAIT_STATE_EN
            R_WAIT: begin
                r_state_d = R_DATA;
                rvalid_d  = 1'b1;
            end
`endif
            R_DATA: begin
                if (RREADY) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    r_state_d = R_IDLE;
                end else begin
                    r_state_d = R_DATA;
                end
            end
            default: begin
                r_state_d = R_IDLE;
                arready_d = 1'b1;
                rvalid_d  = 1'b0;
            end
        endcase
    end

    // Read FSM registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'h0000_0000;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    // Write FSM next state: capture AW and W in any order, commit, then respond
    always_comb begin
        w_state_d = w_state_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        aw_idx_d  = aw_idx_q;
        wdata_d   = wdata_q;
        commit_s  = 1'b0;
`ifdef AXI_MEM_SLAVE_WAIT_STATE_EN
        wcnt_d    = wcnt_q;
`endif
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs_s) begin
                    aw_idx_d  = AWADDR[DEPTH_LOG2+1:2];
                    aw_done_d = 1'b1;
                    awready_d = 1'b0;
                end else begin
                    aw_done_d = aw_done_q;
                end
                if (w_hs_s) begin
                    wdata_d  = WDATA;
                    w_done_d = 1'b1;
                    wready_d = 1'b0;
                end else begin
                    w_done_d = w_done_q;
                end
                if (aw_done_d && w_done_d) begin
                    w_state_d = W_COMMIT;
`ifdef AXI_MEM_SLAVE_WAIT_STATE_EN
                    wcnt_d    = 1'b0;
`endif
                end else begin
                    w_state_d = W_IDLE;
                end
            end
            W_COMMIT: begin
`ifdef AXI_MEM_SLAVE_WAIT_STATE_EN
                if (wcnt_q == 1'b0) begin
                    wcnt_d    = 1'b1;
                    w_state_d = W_COMMIT;
                end else begin
                    commit_s  = 1'b1;
                    bvalid_d  = 1'b1;
                    w_state_d = W_RESP;
                end
`else
                commit_s  = 1'b1;
                bvalid_d  = 1'b1;
                w_state_d = W_RESP;
`endif
            end
            W_RESP: begin
                if (BREADY) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    w_state_d = W_IDLE;
                end else begin
                    w_state_d = W_RESP;
                end
            end
            default: begin
                w_state_d = W_IDLE;
                awready_d = 1'b1;
                wready_d  = 1'b1;
                bvalid_d  = 1'b0;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
            end
        endcase
    end

    // Write FSM registers; reset drops any half-captured transaction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            aw_idx_q  <= '0;
            wdata_q   <= 32'h0000_0000;
`ifdef AXI_MEM_SLAVE_WAIT_STATE_EN
            wcnt_q    <= 1'b0;
`endif
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            aw_idx_q  <= aw_idx_d;
            wdata_q   <= wdata_d;
`ifdef AXI_MEM_SLAVE_WAIT_STATE_EN
            wcnt_q    <= wcnt_d;
`endif
        end
    end

    // Memory array: cleared on reset, written on the commit edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'h0000_0000;
            end
        end else begin
            if (commit_s) begin
                mem_q[aw_idx_q] <= wdata_q;
            end
        end
    end

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench for axi_mem_slave: a vector table of single writes/reads
// followed by hand-written multi-cycle sequences (W before AW, read stall,
// read/commit collision, reset mid-transaction).
module tb_axi_mem_slave;

`ifdef AXI_MEM_SLAVE_WAIT_STATE_EN
    localparam int RLAT = 2;
    localparam int WLAT = 2;
`else
    localparam int RLAT = 1;
    localparam int WLAT = 1;
`endif

    logic        clk;
    logic        reset;
    logic        ARVALID, ARREADY;
    logic [31:0] ARADDR;
    logic        RVALID, RREADY;
    logic [31:0] RDATA;
    logic        AWVALID, AWREADY;
    logic [31:0] AWADDR;
    logic        WVALID, WREADY;
    logic [31:0] WDATA;
    logic        BVALID, BREADY;

    int n_vec;
    int n_err;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } vec_t;

    vec_t tbl [12];

    axi_mem_slave #(.DEPTH_LOG2(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .ARVALID (ARVALID),
        .ARREADY (ARREADY),
        .ARADDR  (ARADDR),
        .RVALID  (RVALID),
        .RREADY  (RREADY),
        .RDATA   (RDATA),
        .AWVALID (AWVALID),
        .AWREADY (AWREADY),
        .AWADDR  (AWADDR),
        .WVALID  (WVALID),
        .WREADY  (WREADY),
        .WDATA   (WDATA),
        .BVALID  (BVALID),
        .BREADY  (BREADY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, {31'd0, act}, {31'd0, exp});
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] exp, input string nm);
        @(negedge clk);
        ARADDR  = a;
        ARVALID = 1'b1;
        RREADY  = 1'b1;
        chk1({nm, "_arready_idle"}, ARREADY, 1'b1);
        cyc();
        ARVALID = 1'b0;
        ARADDR  = 32'h0;
        for (int i = 1; i < RLAT; i++) begin
            chk1({nm, "_rvalid_wait"}, RVALID, 1'b0);
            cyc();
        end
        chk1({nm, "_rvalid"}, RVALID, 1'b1);
        chk({nm, "_rdata"}, RDATA, exp);
        chk1({nm, "_arready_busy"}, ARREADY, 1'b0);
        cyc();
        chk1({nm, "_rvalid_done"}, RVALID, 1'b0);
        chk1({nm, "_arready_back"}, ARREADY, 1'b1);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input string nm);
        @(negedge clk);
        AWADDR  = a;
        AWVALID = 1'b1;
        WDATA   = d;
        WVALID  = 1'b1;
        BREADY  = 1'b1;
        cyc();
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        chk1({nm, "_awready_drop"}, AWREADY, 1'b0);
        chk1({nm, "_wready_drop"}, WREADY, 1'b0);
        for (int i = 0; i < WLAT; i++) begin
            chk1({nm, "_bvalid_commit"}, BVALID, 1'b0);
            cyc();
        end
        chk1({nm, "_bvalid"}, BVALID, 1'b1);
        cyc();
        chk1({nm, "_bvalid_done"}, BVALID, 1'b0);
        chk1({nm, "_awready_back"}, AWREADY, 1'b1);
        chk1({nm, "_wready_back"}, WREADY, 1'b1);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;

        // op, address, write data or expected read data
        tbl[0]  = '{1'b0, 32'h0000_0008, 32'h0000_0000};  // fresh memory reads zero
        tbl[1]  = '{1'b1, 32'h0000_0004, 32'hDEAD_BEEF};
        tbl[2]  = '{1'b0, 32'h0000_0004, 32'hDEAD_BEEF};
        tbl[3]  = '{1'b1, 32'h0000_0044, 32'hA5A5_A5A5};  // aliases word 1
        tbl[4]  = '{1'b0, 32'h0000_0004, 32'hA5A5_A5A5};
        tbl[5]  = '{1'b0, 32'h0000_0044, 32'hA5A5_A5A5};
        tbl[6]  = '{1'b1, 32'h0000_003C, 32'h0BAD_F00D};  // top word
        tbl[7]  = '{1'b0, 32'hFFFF_FFFC, 32'h0BAD_F00D};  // upper bits ignored
        tbl[8]  = '{1'b1, 32'h0000_0003, 32'h1111_1111};  // byte offset ignored
        tbl[9]  = '{1'b0, 32'h0000_0000, 32'h1111_1111};
        tbl[10] = '{1'b0, 32'h0000_0008, 32'h0000_0000};
        tbl[11] = '{1'b0, 32'h0000_003C, 32'h0BAD_F00D};

        reset   = 1'b1;
        ARVALID = 1'b0;
        ARADDR  = 32'h0;
        RREADY  = 1'b0;
        AWVALID = 1'b0;
        AWADDR  = 32'h0;
        WVALID  = 1'b0;
        WDATA   = 32'h0;
        BREADY  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // reset state
        chk1("rst_arready", ARREADY, 1'b1);
        chk1("rst_awready", AWREADY, 1'b1);
        chk1("rst_wready", WREADY, 1'b1);
        chk1("rst_rvalid", RVALID, 1'b0);
        chk1("rst_bvalid", BVALID, 1'b0);
        chk("rst_rdata", RDATA, 32'h0);

        // table-driven single transactions
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].wr) begin
                do_write(tbl[i].addr, tbl[i].data, $sformatf("v%0d_wr", i));
            end else begin
                do_read(tbl[i].addr, tbl[i].data, $sformatf("v%0d_rd", i));
            end
        end

        // W three cycles ahead of AW, response held off by BREADY low
        @(negedge clk);
        BREADY = 1'b0;
        WDATA  = 32'h1234_5678;
        WVALID = 1'b1;
        cyc();
        WVALID = 1'b0;
        WDATA  = 32'h0;
        for (int i = 0; i < 3; i++) begin
            chk1("wfirst_wready_low", WREADY, 1'b0);
            chk1("wfirst_awready_high", AWREADY, 1'b1);
            chk1("wfirst_bvalid_low", BVALID, 1'b0);
            if (i < 2) cyc();
        end
        AWADDR  = 32'h0000_0010;
        AWVALID = 1'b1;
        cyc();
        AWVALID = 1'b0;
        chk1("wfirst_awready_drop", AWREADY, 1'b0);
        for (int i = 0; i < WLAT; i++) begin
            chk1("wfirst_bvalid_commit", BVALID, 1'b0);
            cyc();
        end
        for (int i = 0; i < 3; i++) begin
            chk1("wfirst_bvalid_hold", BVALID, 1'b1);
            if (i < 2) cyc();
        end
        BREADY = 1'b1;
        cyc();
        chk1("wfirst_bvalid_done", BVALID, 1'b0);
        chk1("wfirst_wready_back", WREADY, 1'b1);
        do_read(32'h0000_0010, 32'h1234_5678, "wfirst_rd");

        // read stalled by RREADY low for five cycles
        @(negedge clk);
        RREADY  = 1'b0;
        ARADDR  = 32'h0000_0010;
        ARVALID = 1'b1;
        cyc();
        ARVALID = 1'b0;
        for (int i = 1; i < RLAT; i++) cyc();
        for (int i = 0; i < 5; i++) begin
            chk1("stall_rvalid", RVALID, 1'b1);
            chk("stall_rdata", RDATA, 32'h1234_5678);
            chk1("stall_arready", ARREADY, 1'b0);
            cyc();
        end
        RREADY = 1'b1;
        cyc();
        chk1("stall_rvalid_done", RVALID, 1'b0);
        chk1("stall_arready_back", ARREADY, 1'b1);

        // AR handshake on the same edge as a commit to the same word
        @(negedge clk);
        BREADY  = 1'b0;
        RREADY  = 1'b0;
        AWADDR  = 32'h0000_0020;
        AWVALID = 1'b1;
        WDATA   = 32'h7777_7777;
        WVALID  = 1'b1;
        cyc();
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        for (int i = 1; i < WLAT; i++) cyc();
        ARADDR  = 32'h0000_0020;
        ARVALID = 1'b1;
        cyc();
        ARVALID = 1'b0;
        chk1("coll_bvalid", BVALID, 1'b1);
        for (int i = 1; i < RLAT; i++) cyc();
        chk1("coll_rvalid", RVALID, 1'b1);
        chk("coll_rdata_old", RDATA, 32'h0000_0000);
        RREADY = 1'b1;
        BREADY = 1'b1;
        cyc();
        chk1("coll_rvalid_done", RVALID, 1'b0);
        chk1("coll_bvalid_done", BVALID, 1'b0);
        do_read(32'h0000_0020, 32'h7777_7777, "coll_rd_new");

        // reset after AW capture but before W
        @(negedge clk);
        BREADY  = 1'b1;
        AWADDR  = 32'h0000_003C;
        AWVALID = 1'b1;
        cyc();
        AWVALID = 1'b0;
        chk1("mid_awready_drop", AWREADY, 1'b0);
        reset = 1'b1;
        #1;
        chk1("mid_arready", ARREADY, 1'b1);
        chk1("mid_awready", AWREADY, 1'b1);
        chk1("mid_wready", WREADY, 1'b1);
        chk1("mid_bvalid", BVALID, 1'b0);
        chk1("mid_rvalid", RVALID, 1'b0);
        chk("mid_rdata", RDATA, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        // a lone W after reset must not complete against the discarded AW
        WDATA  = 32'h5555_5555;
        WVALID = 1'b1;
        cyc();
        WVALID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk1("mid_no_commit_bvalid", BVALID, 1'b0);
            chk1("mid_awready_open", AWREADY, 1'b1);
            cyc();
        end
        do_read(32'h0000_003C, 32'h0000_0000, "mid_rd_cleared");
        @(negedge clk);
        AWADDR  = 32'h0000_003C;
        AWVALID = 1'b1;
        cyc();
        AWVALID = 1'b0;
        for (int i = 0; i < WLAT; i++) cyc();
        chk1("mid_late_bvalid", BVALID, 1'b1);
        cyc();
        chk1("mid_late_bvalid_done", BVALID, 1'b0);
        do_read(32'h0000_003C, 32'h5555_5555, "mid_rd_late");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axi_mem_slave.md
AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, log2 of memory depth in 32-bit words (16 words).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports ARVALID in 1, ARREADY out 1, ARADDR in 32: read address channel.
REQ-005 SHALL have ports RVALID out 1, RREADY in 1, RDATA out 32: read data channel.
REQ-006 SHALL have ports AWVALID in 1, AWREADY out 1, AWADDR in 32: write address channel.
REQ-007 SHALL have ports WVALID in 1, WREADY out 1, WDATA in 32: write data channel.
REQ-008 SHALL have ports BVALID out 1, BREADY in 1: write response channel.
REQ-009 SHALL drive all outputs from registers; no combinational input-to-output path.

Function
REQ-010 SHALL hold a 2^DEPTH_LOG2 x 32 memory; word index = ADDR[DEPTH_LOG2+1:2]; ADDR[1:0] and upper bits ignored (addresses alias/wrap).
REQ-011 Handshake = VALID and READY high at same rising edge; SHALL hold RVALID/RDATA and BVALID stable until their handshake.
REQ-012 Read FSM states R_IDLE (ARREADY=1) and R_DATA (RVALID=1, ARREADY=0).
REQ-013 In R_IDLE on AR handshake: latch RDATA=mem[index], go R_DATA; RVALID high the next cycle (latency 1).
REQ-014 In R_DATA on R handshake: RVALID<=0, ARREADY<=1, return to R_IDLE; one bubble cycle between reads.
REQ-015 Write FSM states W_IDLE, W_COMMIT, W_RESP; W_IDLE accepts AW and W independently, in either order or the same cycle.
REQ-016 AWREADY SHALL drop the cycle after AW handshake; WREADY SHALL drop the cycle after W handshake; each captured value is held.
REQ-017 When both AW and W are captured: go W_COMMIT, write mem[index]=WDATA at the next edge, and set BVALID=1 in the same edge (go W_RESP).
REQ-018 In W_RESP on B handshake: BVALID<=0, AWREADY<=1, WREADY<=1, go W_IDLE.
REQ-019 Read and write paths SHALL operate concurrently and independently.
REQ-020 If AR handshake and write commit hit the same word on the same edge, RDATA SHALL return the pre-write value.
REQ-021 A read issued after BVALID has been observed SHALL return the newly written data.

Reset
REQ-022 On reset: ARREADY=1, AWREADY=1, WREADY=1, RVALID=0, BVALID=0, RDATA=0, FSMs idle, all memory words=0.
REQ-023 Reset asserted mid-transaction SHALL discard captured AW/W/AR state; no partial write is committed after reset.

Configuration
REQ-024 Macro AXI_MEM_SLAVE_WAIT_STATE_EN: when defined, an extra R_WAIT state is inserted between R_IDLE and R_DATA, so RVALID rises 2 cycles after the AR handshake, and W_COMMIT lasts 2 cycles, so BVALID rises 2 cycles after both AW and W are captured.
REQ-025 Without the macro, latencies are exactly as in REQ-013/REQ-017.

Verification
REQ-026 Reset, then read 0x0000_0008 with RREADY=1 -> RVALID one cycle after handshake, RDATA=0x0000_0000.
REQ-027 AW=0x04 and W=0xDEADBEEF in the same cycle, BREADY=1 -> BVALID after commit; a read of 0x04 returns 0xDEADBEEF.
REQ-028 W=0x12345678 three cycles before AW=0x10 -> WREADY low after W, single commit, read 0x10 = 0x12345678.
REQ-029 Write 0xA5A5A5A5 to 0x44 (DEPTH_LOG2=4) -> read 0x04 returns 0xA5A5A5A5 (alias).
REQ-030 RREADY held low 5 cycles -> RVALID and RDATA stable throughout, ARREADY low until handshake.
REQ-031 Assert reset after AW capture but before W -> no memory change, all READYs=1, BVALID=0.
